// File: rtl/placer_request_sequencer.sv
// Placer request sequencer: queues host rectangles, issues one per 4-cycle slot
// to a fixed-latency placer, and tags the placer's answer with the issued size.
// Latency: first issue at the next slot boundary, result strobe LAT+2 cycles after issue.
// Backpressure: req_ready_o drops only when the FIFO holds DEPTH entries.
module placer_request_sequencer #(
  parameter int DEPTH = 8,
  parameter int LAT   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [4:0]                 req_height_i,
  input  logic [4:0]                 req_width_i,
  output logic [4:0]                 height_o,
  output logic [4:0]                 width_o,
  input  logic [7:0]                 index_x_i,
  input  logic [7:0]                 index_y_i,
  input  logic [3:0]                 strike_i,
  output logic                       res_valid_o,
  output logic [4:0]                 res_height_o,
  output logic [4:0]                 res_width_o,
  output logic [7:0]                 res_x_o,
  output logic [7:0]                 res_y_o,
  output logic [3:0]                 res_strike_o,
  output logic [$clog2(DEPTH):0]     fifo_count_o,
  output logic                       busy_o
);

  localparam int AW = $clog2(DEPTH);
  // Tag slots: an entry issued at a slot boundary reaches the last slot after
  // LAT/4 further boundaries, which is where its placer answer becomes due.
  localparam int NT = LAT / 4 + 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef struct packed {
    logic       vld;
    logic [4:0] h;
    logic [4:0] w;
  } tag_t;

  logic [1:0]    slot;
  logic [4:0]    fifo_h [DEPTH];
  logic [4:0]    fifo_w [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  tag_t          tags [NT];

  logic slot_end;
  logic push;
  logic pop;
  logic res_take;
  logic any_tag;

  // Zero-sized requests are handshaken but dropped; pop only at the 3->0 edge.
  assign slot_end    = (slot == 2'd3);
  assign req_ready_o = (count < FULL_CNT);
  assign push        = req_valid_i && req_ready_o &&
                       (req_height_i != 5'd0) && (req_width_i != 5'd0);
  assign pop         = slot_end && (count != '0);
  // The oldest tag is sampled at the edge ending issue cycle T+LAT+1. With LAT a
  // multiple of 4, that edge always leaves slot phase 1.
  assign res_take     = (slot == 2'd1) && tags[NT-1].vld;
  assign fifo_count_o = count;

  // Free-running slot phase; first edge out of reset is the 0->1 edge.
  always_ff @(posedge clk) begin
    if (!rst) slot <= 2'd0;
    else      slot <= slot + 2'd1;
  end

  // FIFO payload storage; contents are don't-care while pointers are reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_h[wr_ptr] <= req_height_i;
      fifo_w[wr_ptr] <= req_width_i;
    end
  end

  // FIFO pointers and occupancy; push and pop on the same edge cancel out.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Placer drive: load head (or an idle 0/0) once per slot and hold for 4 cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      height_o <= 5'd0;
      width_o  <= 5'd0;
    end else if (slot_end) begin
      height_o <= pop ? fifo_h[rd_ptr] : 5'd0;
      width_o  <= pop ? fifo_w[rd_ptr] : 5'd0;
    end
  end

  // In-flight tag line, one entry per slot; idle slots shift in an invalid tag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NT; i++) tags[i] <= '0;
    end else if (slot_end) begin
      tags[0].vld <= pop;
      tags[0].h   <= pop ? fifo_h[rd_ptr] : 5'd0;
      tags[0].w   <= pop ? fifo_w[rd_ptr] : 5'd0;
      for (int i = 1; i < NT; i++) tags[i] <= tags[i-1];
    end
  end

  // Result capture: one-cycle strobe, payload held until the next result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      res_valid_o  <= 1'b0;
      res_height_o <= 5'd0;
      res_width_o  <= 5'd0;
      res_x_o      <= 8'd0;
      res_y_o      <= 8'd0;
      res_strike_o <= 4'd0;
    end else begin
      res_valid_o <= res_take;
      if (res_take) begin
        res_height_o <= tags[NT-1].h;
        res_width_o  <= tags[NT-1].w;
        res_x_o      <= index_x_i;
        res_y_o      <= index_y_i;
        res_strike_o <= strike_i;
      end
    end
  end

  // Busy while anything is queued or any issued entry still awaits its answer.
  always_comb begin
    any_tag = 1'b0;
    for (int i = 0; i < NT; i++) any_tag = any_tag | tags[i].vld;
    busy_o = (count != '0) || any_tag;
  end

endmodule

// File: tb/tb_placer_request_sequencer.sv
// Directed bench for placer_request_sequencer with a fixed-latency placer model.
// Latency: placer answer derived from the size driven LAT cycles earlier.
// Backpressure: requests are held until req_ready_o accepts them.
module tb_placer_request_sequencer;

  localparam int DEPTH = 8;
  localparam int LAT   = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid_i = 1'b0;
  logic       req_ready_o;
  logic [4:0] req_height_i = 5'd0;
  logic [4:0] req_width_i = 5'd0;
  logic [4:0] height_o, width_o;
  logic [7:0] index_x_i, index_y_i;
  logic [3:0] strike_i;
  logic       res_valid_o;
  logic [4:0] res_height_o, res_width_o;
  logic [7:0] res_x_o, res_y_o;
  logic [3:0] res_strike_o;
  logic [3:0] fifo_count_o;
  logic       busy_o;

  int checks = 0;
  int fails  = 0;

  placer_request_sequencer #(.DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_height_i(req_height_i), .req_width_i(req_width_i),
    .height_o(height_o), .width_o(width_o),
    .index_x_i(index_x_i), .index_y_i(index_y_i), .strike_i(strike_i),
    .res_valid_o(res_valid_o),
    .res_height_o(res_height_o), .res_width_o(res_width_o),
    .res_x_o(res_x_o), .res_y_o(res_y_o), .res_strike_o(res_strike_o),
    .fifo_count_o(fifo_count_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Placer model: answer depends on the size seen LAT cycles ago.
  logic [9:0] pl [0:LAT];
  always @(posedge clk) begin
    pl[0] <= {height_o, width_o};
    for (int i = 1; i <= LAT; i++) pl[i] <= pl[i-1];
  end

  function automatic logic [7:0] fx(input logic [4:0] h, input logic [4:0] w);
    return {3'b0, h} + {3'b0, w};
  endfunction
  function automatic logic [7:0] fy(input logic [4:0] w);
    return {4'b0, w[4:1]};
  endfunction
  function automatic logic [3:0] fs(input logic [4:0] h);
    return h[3:0] ^ 4'd4;
  endfunction

  assign index_x_i = fx(pl[LAT][9:5], pl[LAT][4:0]);
  assign index_y_i = fy(pl[LAT][4:0]);
  assign strike_i  = fs(pl[LAT][9:5]);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves rst high just after an edge, so the next edge is E1 (slot 0->1).
  task automatic apply_reset();
    rst = 1'b0;
    req_valid_i = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_valid_i = 1'b0;
    repeat (3) tick();
    checks++; if (fifo_count_o !== 4'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", fifo_count_o); end
    checks++; if (req_ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", req_ready_o); end
    checks++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    checks++; if ({height_o, width_o} !== 10'd0) begin fails++; $display("FAIL reset_hw: got %0d/%0d want 0/0", height_o, width_o); end
    checks++; if (res_valid_o !== 1'b0 || {res_height_o, res_width_o, res_x_o, res_y_o, res_strike_o} !== 30'd0) begin
      fails++; $display("FAIL reset_res: got vld=%b x=%0d y=%0d want all 0", res_valid_o, res_x_o, res_y_o);
    end
    rst = 1'b1;
  endtask

  task automatic test_single();
    apply_reset();
    req_valid_i = 1'b1; req_height_i = 5'd4; req_width_i = 5'd6;
    tick();                                       // E1: accepted
    req_valid_i = 1'b0;
    checks++; if (fifo_count_o !== 4'd1 || busy_o !== 1'b1) begin fails++; $display("FAIL single_push: got cnt=%0d busy=%b want 1/1", fifo_count_o, busy_o); end
    repeat (3) tick();                            // E4: issue, cycle T
    checks++; if (height_o !== 5'd4 || width_o !== 5'd6) begin fails++; $display("FAIL single_issue: got %0d/%0d want 4/6", height_o, width_o); end
    checks++; if (fifo_count_o !== 4'd0) begin fails++; $display("FAIL single_pop_count: got %0d want 0", fifo_count_o); end
    repeat (3) tick();                            // E7: T+3
    checks++; if (height_o !== 5'd4 || width_o !== 5'd6) begin fails++; $display("FAIL single_hold: got %0d/%0d want 4/6", height_o, width_o); end
    tick();                                       // E8: idle slot
    checks++; if (height_o !== 5'd0 || width_o !== 5'd0) begin fails++; $display("FAIL single_idle_slot: got %0d/%0d want 0/0", height_o, width_o); end
    for (int e = 9; e <= 13; e++) begin
      tick();
      checks++; if (res_valid_o !== 1'b0) begin fails++; $display("FAIL single_early_res: edge %0d got %b want 0", e, res_valid_o); end
    end
    tick();                                       // E14: cycle T+10
    checks++; if (res_valid_o !== 1'b1) begin fails++; $display("FAIL single_res_valid: got %b want 1", res_valid_o); end
    checks++; if (res_height_o !== 5'd4 || res_width_o !== 5'd6 || res_x_o !== 8'd10 || res_y_o !== 8'd3 || res_strike_o !== 4'd0) begin
      fails++; $display("FAIL single_res_data: got %0d,%0d,%0d,%0d,%0d want 4,6,10,3,0", res_height_o, res_width_o, res_x_o, res_y_o, res_strike_o);
    end
    tick();                                       // E15
    checks++; if (res_valid_o !== 1'b0 || res_x_o !== 8'd10 || res_height_o !== 5'd4) begin
      fails++; $display("FAIL single_res_hold: got vld=%b x=%0d h=%0d want 0,10,4", res_valid_o, res_x_o, res_height_o);
    end
    repeat (4) tick();                            // E19: last tag has shifted out
    checks++; if (busy_o !== 1'b0) begin fails++; $display("FAIL single_busy_end: got %b want 0", busy_o); end
  endtask

  task automatic test_fill();
    int exp_cnt [13];
    bit exp_rdy [13];
    int k;
    bit acc;
    exp_cnt = '{1, 2, 3, 3, 4, 5, 6, 6, 7, 8, 8, 7, 8};
    exp_rdy = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 0};
    apply_reset();
    k = 1;
    for (int e = 0; e < 13; e++) begin
      req_valid_i = 1'b1;
      req_height_i = 5'(k);
      req_width_i = 5'(k + 1);
      acc = req_ready_o;
      tick();
      if (acc) k++;
      checks++; if (fifo_count_o !== 4'(exp_cnt[e]) || req_ready_o !== exp_rdy[e]) begin
        fails++; $display("FAIL fill_E%0d: got cnt=%0d rdy=%b want %0d/%b", e + 1, fifo_count_o, req_ready_o, exp_cnt[e], exp_rdy[e]);
      end
      if (e == 3 || e == 7 || e == 11) begin
        checks++; if (height_o !== 5'((e + 1) / 4) || width_o !== 5'((e + 1) / 4 + 1)) begin
          fails++; $display("FAIL fill_order_E%0d: got %0d/%0d want %0d/%0d", e + 1, height_o, width_o, (e + 1) / 4, (e + 1) / 4 + 1);
        end
      end
    end
    req_valid_i = 1'b0;
    checks++; if (k !== 12) begin fails++; $display("FAIL fill_accepts: got %0d want 11", k - 1); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int k = 1; k <= 5; k++) begin
      req_valid_i = 1'b1; req_height_i = 5'(k + 2); req_width_i = 5'(k);
      tick();
    end
    req_valid_i = 1'b0;
    repeat (3) tick();                            // E8: 3 queued, 2 in flight
    checks++; if (fifo_count_o !== 4'd3 || busy_o !== 1'b1) begin fails++; $display("FAIL midrst_before: got cnt=%0d busy=%b want 3/1", fifo_count_o, busy_o); end
    rst = 1'b0;
    tick();
    checks++; if (fifo_count_o !== 4'd0 || busy_o !== 1'b0 || height_o !== 5'd0 || width_o !== 5'd0 || res_valid_o !== 1'b0) begin
      fails++; $display("FAIL midrst_clear: got cnt=%0d busy=%b h=%0d w=%0d rv=%b want 0", fifo_count_o, busy_o, height_o, width_o, res_valid_o);
    end
    rst = 1'b1;
    checks++; if (req_ready_o !== 1'b1) begin fails++; $display("FAIL midrst_ready: got %b want 1", req_ready_o); end
    for (int c = 0; c < 30; c++) begin
      tick();
      checks++; if (res_valid_o !== 1'b0 || busy_o !== 1'b0) begin fails++; $display("FAIL midrst_ghost: cycle %0d got rv=%b busy=%b want 0/0", c, res_valid_o, busy_o); end
    end
  endtask

  task automatic test_idle();
    for (int c = 0; c < 40; c++) begin
      tick();
      checks++; if (height_o !== 5'd0 || width_o !== 5'd0 || res_valid_o !== 1'b0 || busy_o !== 1'b0) begin
        fails++; $display("FAIL idle: cycle %0d got h=%0d w=%0d rv=%b busy=%b want 0", c, height_o, width_o, res_valid_o, busy_o);
      end
    end
  endtask

  task automatic test_zero_size();
    int pulses;
    req_valid_i = 1'b1; req_height_i = 5'd0; req_width_i = 5'd5;
    tick();
    checks++; if (fifo_count_o !== 4'd0) begin fails++; $display("FAIL zero_drop: got cnt=%0d want 0", fifo_count_o); end
    req_height_i = 5'd3; req_width_i = 5'd3;
    tick();
    req_valid_i = 1'b0;
    checks++; if (fifo_count_o !== 4'd1) begin fails++; $display("FAIL zero_keep: got cnt=%0d want 1", fifo_count_o); end
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (res_valid_o === 1'b1) begin
        pulses++;
        checks++; if (res_height_o !== 5'd3 || res_width_o !== 5'd3 || res_x_o !== 8'd6 || res_y_o !== 8'd1 || res_strike_o !== 4'd7) begin
          fails++; $display("FAIL zero_res: got %0d,%0d,%0d,%0d,%0d want 3,3,6,1,7", res_height_o, res_width_o, res_x_o, res_y_o, res_strike_o);
        end
      end
    end
    checks++; if (pulses !== 1) begin fails++; $display("FAIL zero_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] eh[$];
    logic [4:0] ew[$];
    int sent, got, cyc, last;
    bit acc;
    sent = 0; got = 0; last = 0;
    for (cyc = 0; cyc < 400 && got < 20; cyc++) begin
      req_valid_i = (sent < 20);
      req_height_i = 5'(sent + 1);
      req_width_i = 5'(20 - sent);
      acc = req_valid_i && req_ready_o;
      tick();
      if (acc) begin
        eh.push_back(5'(sent + 1));
        ew.push_back(5'(20 - sent));
        sent++;
      end
      if (res_valid_o === 1'b1) begin
        if (eh.size() == 0) begin
          checks++; fails++; $display("FAIL stream_extra: unexpected result h=%0d", res_height_o);
        end else begin
          checks++; if (res_height_o !== eh[0] || res_width_o !== ew[0] || res_x_o !== fx(eh[0], ew[0]) ||
                        res_y_o !== fy(ew[0]) || res_strike_o !== fs(eh[0])) begin
            fails++; $display("FAIL stream_res%0d: got %0d,%0d,%0d,%0d,%0d want %0d,%0d,%0d,%0d,%0d", got,
                              res_height_o, res_width_o, res_x_o, res_y_o, res_strike_o,
                              eh[0], ew[0], fx(eh[0], ew[0]), fy(ew[0]), fs(eh[0]));
          end
          void'(eh.pop_front());
          void'(ew.pop_front());
        end
        if (got > 0) begin
          checks++; if (cyc - last !== 4) begin fails++; $display("FAIL stream_spacing%0d: got %0d want 4", got, cyc - last); end
        end
        last = cyc;
        got++;
      end
    end
    req_valid_i = 1'b0;
    checks++; if (got !== 20 || sent !== 20) begin fails++; $display("FAIL stream_total: got %0d results %0d sent want 20/20", got, sent); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_reset_mid();
    test_idle();
    test_zero_size();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
